// File: rtl/config_reporter_if.sv
// UART TX byte handshake between config_reporter (master) and the transmitter (slave).
interface config_reporter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/config_reporter.sv
// Serialises snapshotted mode/brightness/animation registers into command-format bytes.
// Define CONFIG_REPORTER_CHECKSUM_EN to append an XOR checksum byte to each frame.
module config_reporter #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter logic [3:0]  HDR_INDEX  = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              report_req,
    input  logic [3:0]        mode,
    input  logic [3:0]        brightness,
    input  logic [3:0]        animation_sel,
    config_reporter_if.master tx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

`ifdef CONFIG_REPORTER_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t          state;
    logic [2:0]      byte_idx;
    logic [GW-1:0]   gap_cnt;
    logic            pending;
    logic [3:0]      snap_mode;
    logic [3:0]      snap_bri;
    logic [3:0]      snap_anim;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            start_frame;

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [3:0] m,
                                              input logic [3:0] b,
                                              input logic [3:0] a);
        logic [7:0] fb;
        fb = '0;
        case (idx)
            3'd0: fb = {HDR_INDEX, 4'h3};
            3'd1: fb = {4'h0, m};
            3'd2: fb = {4'hA, b};
            3'd3: fb = {4'h1, a};
`ifdef CONFIG_REPORTER_CHECKSUM_EN
            // High nibble folds the constant indices 0^A^1 = B into the header index.
            3'd4: fb = {HDR_INDEX ^ 4'hB, 4'h3 ^ m ^ b ^ a};
`endif
            default: fb = '0;
        endcase
        return fb;
    endfunction

    // A queued request restarts straight from DONE; IDLE also drains one left by DONE.
    always_comb begin
        start_frame = ((state == IDLE) && (report_req || pending)) ||
                      ((state == DONE) && pending);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_idx   <= '0;
            gap_cnt    <= '0;
            pending    <= 1'b0;
            snap_mode  <= '0;
            snap_bri   <= '0;
            snap_anim  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_frame) begin
                snap_mode  <= mode;
                snap_bri   <= brightness;
                snap_anim  <= animation_sel;
                tx_data_q  <= {HDR_INDEX, 4'h3};
                tx_valid_q <= 1'b1;
                byte_idx   <= '0;
                gap_cnt    <= '0;
                pending    <= 1'b0;
                busy       <= 1'b1;
                state      <= SEND;
            end else begin
                case (state)
                    IDLE: busy <= 1'b0;
                    SEND: begin
                        if (report_req) pending <= 1'b1;
                        if (tx.tx_ready) begin
                            if (byte_idx == LAST_IDX) begin
                                tx_valid_q <= 1'b0;
                                done       <= 1'b1;
                                state      <= DONE;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                                if (GAP_CYCLES > 0) begin
                                    tx_valid_q <= 1'b0;
                                    gap_cnt    <= '0;
                                    state      <= GAP;
                                end else begin
                                    tx_data_q <= frame_byte(byte_idx + 3'd1, snap_mode,
                                                            snap_bri, snap_anim);
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (report_req) pending <= 1'b1;
                        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                            tx_data_q  <= frame_byte(byte_idx, snap_mode, snap_bri, snap_anim);
                            tx_valid_q <= 1'b1;
                            state      <= SEND;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        pending <= report_req;
                        busy    <= report_req;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
